// File: rtl/sync_event_arbiter.sv
// ---------------------------------------------------------------------------
// sync_event_arbiter : rising-edge event capture with round-robin channel share
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_event_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_sync,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_chan,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     overrun,
    input  logic [N-1:0]     ovr_clr
);

    localparam logic [0:0]       IDLE    = 1'b0;
    localparam logic [0:0]       OFFER   = 1'b1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N - 1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [N-1:0]     prev;
    logic             armed;
    logic [IDX_W-1:0] last_grant;

    logic [N-1:0]     edge_det;
    logic [N-1:0]     acc;
    logic [N-1:0]     pending_nxt;
    logic [N-1:0]     overrun_nxt;

    logic             hi_found;
    logic [IDX_W-1:0] hi_sel;
    logic             lo_found;
    logic [IDX_W-1:0] lo_sel;
    logic             sel_found;
    logic [IDX_W-1:0] sel_chan;

    logic             load_offer;
    logic             take;

    // Levels already high when the block comes out of reset must not count as edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= in_sync;
            armed <= 1'b1;
        end
    end

    always_comb begin
        edge_det = {N{armed}} & in_sync & ~prev;
        acc      = '0;
        for (int i = 0; i < N; i++) begin
            acc[i] = ev_valid & ev_ready & (ev_chan == IDX_W'(i));
        end
        // An edge coinciding with acceptance re-arms the request instead of overrunning.
        pending_nxt = edge_det | (pending & ~acc);
        overrun_nxt = (edge_det & pending & ~acc) | (overrun & ~ovr_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    // Round-robin pick: lowest pending index above last_grant, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_found = 1'b0;
        lo_sel   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_found = 1'b1;
                lo_sel   = IDX_W'(i);
            end
            if (pending[i] && (IDX_W'(i) > last_grant)) begin
                hi_found = 1'b1;
                hi_sel   = IDX_W'(i);
            end
        end
        sel_found = hi_found | lo_found;
        sel_chan  = hi_found ? hi_sel : lo_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = OFFER;
            OFFER:   if (ev_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_offer = (state == IDLE) & sel_found;
        take       = (state == OFFER) & ev_ready;
        ev_valid   = (state == OFFER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_chan    <= '0;
            last_grant <= LAST_CH;
        end else begin
            if (load_offer) ev_chan <= sel_chan;
            if (take)       last_grant <= ev_chan;
        end
    end

endmodule

`default_nettype wire
